status_flag_gen: RTL and testbench



---
 rtl/status_flag_gen_pkg.sv | 21 ++
 rtl/status_flag_gen_lane_flag_eval.sv | 22 ++
 rtl/status_flag_gen.sv | 166 ++++++++++++++++
 tb/tb_status_flag_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/status_flag_gen_pkg.sv
// Shared constants for the ALU status-flag producer: lane geometry defaults,
// flag bit positions within the 5-bit status word, and the sequencer states.
package status_flag_gen_pkg;

  localparam int LANES_DEF  = 4;
  localparam int LANE_W_DEF = 8;
  localparam int FLAGS_W    = 5;

  localparam int FLG_Z  = 0;
  localparam int FLG_N  = 1;
  localparam int FLG_C  = 2;
  localparam int FLG_V  = 3;
  localparam int FLG_PZ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/status_flag_gen_lane_flag_eval.sv
// Condition bits of a single lane: zero detect, sign bit, and pass-through of
// the lane's carry and overflow. Also used at full word width for scalar results.
module lane_flag_eval
  import status_flag_gen_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [LANE_W-1:0] lane,
  input  logic              carry,
  input  logic              ovf,
  output logic              is_zero,
  output logic              msb,
  output logic              c,
  output logic              v
);

  assign is_zero = (lane == '0);
  assign msb     = lane[LANE_W-1];
  assign c       = carry;
  assign v       = ovf;

endmodule

// File: rtl/status_flag_gen.sv
// Status-register flag producer: latches an ALU result, scans it one lane per
// cycle (or once for scalar results), then issues a one-cycle flag write.
module status_flag_gen
  import status_flag_gen_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic                    SIMD,
  input  logic [LANES*LANE_W-1:0] RES,
  input  logic [LANES-1:0]        CARRY,
  input  logic [LANES-1:0]        OVF,
  output logic                    BUSY,
  output logic [FLAGS_W-1:0]      FLAGS,
  output logic                    FLAGS_WE
);

  localparam int RES_W = LANES * LANE_W;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int ZC_W  = $clog2(LANES + 1);

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
  localparam logic [ZC_W-1:0]  ALL_ZERO  = ZC_W'(LANES);

  function automatic logic [FLAGS_W-1:0] pack_flags(
    input logic pz, input logic v, input logic c, input logic n, input logic z
  );
    logic [FLAGS_W-1:0] f;
    f         = '0;
    f[FLG_Z]  = z;
    f[FLG_N]  = n;
    f[FLG_C]  = c;
    f[FLG_V]  = v;
    f[FLG_PZ] = pz;
    return f;
  endfunction

  state_t state, state_nxt;
  logic   accept, last_scan;

  logic [RES_W-1:0] res_p0;
  logic [LANES-1:0] carry_p0, ovf_p0;
  logic             simd_p0;

  logic [CNT_W-1:0] cnt;
  logic [ZC_W-1:0]  zero_cnt, zero_cnt_nxt;
  logic             n_acc, c_acc, v_acc;
  logic             n_acc_nxt, c_acc_nxt, v_acc_nxt;

  logic [LANE_W-1:0] lanes [LANES];
  logic              lane_zero, lane_msb, lane_c, lane_v;
  logic              word_zero, word_msb, word_c, word_v;
  logic [FLAGS_W-1:0] flags_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_scan = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (START) begin
          accept    = 1'b1;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!simd_p0 || cnt == LAST_LANE) begin
          last_scan = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign BUSY = (state != ST_IDLE);

  // Stage p0: operand capture at accept; later input changes are invisible.
  always_ff @(posedge CLK) begin
    if (accept) begin
      res_p0   <= RES;
      carry_p0 <= CARRY;
      ovf_p0   <= OVF;
      simd_p0  <= SIMD;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lanes[i] = res_p0[i*LANE_W +: LANE_W];
    end
  end

  lane_flag_eval #(.LANE_W(LANE_W)) u_lane (
    .lane    (lanes[cnt]),
    .carry   (carry_p0[cnt]),
    .ovf     (ovf_p0[cnt]),
    .is_zero (lane_zero),
    .msb     (lane_msb),
    .c       (lane_c),
    .v       (lane_v)
  );

  lane_flag_eval #(.LANE_W(RES_W)) u_word (
    .lane    (res_p0),
    .carry   (carry_p0[LANES-1]),
    .ovf     (ovf_p0[LANES-1]),
    .is_zero (word_zero),
    .msb     (word_msb),
    .c       (word_c),
    .v       (word_v)
  );

  // Folding in the current lane lets the final lane land directly in FLAGS.
  always_comb begin
    zero_cnt_nxt = zero_cnt + ZC_W'(lane_zero);
    n_acc_nxt    = n_acc | lane_msb;
    c_acc_nxt    = c_acc | lane_c;
    v_acc_nxt    = v_acc | lane_v;
    if (simd_p0) begin
      flags_nxt = pack_flags((zero_cnt_nxt != '0) && (zero_cnt_nxt != ALL_ZERO),
                             v_acc_nxt, c_acc_nxt, n_acc_nxt,
                             zero_cnt_nxt == ALL_ZERO);
    end else begin
      flags_nxt = pack_flags(1'b0, word_v, word_c, word_msb, word_zero);
    end
  end

  // Stage p1: lane accumulation across SCAN cycles.
  always_ff @(posedge CLK) begin
    if (RESET || accept) begin
      cnt      <= '0;
      zero_cnt <= '0;
      n_acc    <= 1'b0;
      c_acc    <= 1'b0;
      v_acc    <= 1'b0;
    end else if (state == ST_SCAN) begin
      cnt      <= cnt + CNT_W'(1);
      zero_cnt <= zero_cnt_nxt;
      n_acc    <= n_acc_nxt;
      c_acc    <= c_acc_nxt;
      v_acc    <= v_acc_nxt;
    end
  end

  // Stage p2: flag word and write strobe, both valid during WRITE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      FLAGS    <= '0;
      FLAGS_WE <= 1'b0;
    end else begin
      FLAGS_WE <= last_scan;
      if (last_scan) FLAGS <= flags_nxt;
    end
  end

endmodule

// File: tb/tb_status_flag_gen.sv
// Directed and randomized checks of status_flag_gen against a lane-counting
// reference model of the flag rules.
module tb_status_flag_gen;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  logic        CLK = 1'b0;
  logic        RESET, START, SIMD;
  logic [31:0] RES;
  logic [3:0]  CARRY, OVF;
  logic        BUSY, FLAGS_WE;
  logic [4:0]  FLAGS;

  int n_assert = 0;
  int n_fail   = 0;
  logic [4:0] held_flags = 5'b0;

  status_flag_gen #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .SIMD     (SIMD),
    .RES      (RES),
    .CARRY    (CARRY),
    .OVF      (OVF),
    .BUSY     (BUSY),
    .FLAGS    (FLAGS),
    .FLAGS_WE (FLAGS_WE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model(input bit simd, input logic [31:0] r,
                                       input logic [3:0] c, input logic [3:0] o);
    int zeros;
    bit neg;
    zeros = 0;
    neg   = 1'b0;
    if (!simd) return {1'b0, o[3], c[3], r[31], (r == 32'h0)};
    for (int i = 0; i < LANES; i++) begin
      if (r[i*LANE_W +: LANE_W] == 8'h00) zeros++;
      neg |= r[i*LANE_W + LANE_W - 1];
    end
    return {(zeros > 0 && zeros < LANES), |o, |c, neg, (zeros == LANES)};
  endfunction

  // Issues one request and follows it until BUSY drops after the write.
  // disturb: hold START high and scramble operands while busy.
  task automatic do_op(input string tag, input bit simd, input logic [31:0] res,
                       input logic [3:0] c, input logic [3:0] o,
                       input logic [4:0] exp, input bit disturb);
    int busy_cyc, we_cnt, we_at;
    bit done;
    busy_cyc = 0; we_cnt = 0; we_at = -1; done = 1'b0;
    START = 1'b1; SIMD = simd; RES = res; CARRY = c; OVF = o;
    tick();
    START = 1'b0;
    if (disturb) begin
      START = 1'b1; SIMD = ~simd; RES = ~res; CARRY = ~c; OVF = ~o;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      if (!BUSY && we_cnt > 0) begin
        done = 1'b1;
      end else begin
        if (BUSY) busy_cyc++;
        if (FLAGS_WE) begin
          we_cnt++;
          we_at = busy_cyc;
          check({tag, "_flags"}, {27'b0, FLAGS}, {27'b0, exp});
          held_flags = exp;
          START = 1'b0;
        end else begin
          check({tag, "_held"}, {27'b0, FLAGS}, {27'b0, held_flags});
        end
        if (!done) tick();
      end
    end
    START = 1'b0;
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_we_cnt"}, we_cnt, 32'd1);
    check({tag, "_busy_len"}, busy_cyc, simd ? LANES + 1 : 2);
    check({tag, "_we_last"}, we_at, busy_cyc);
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  rc, ro;
    bit          s;

    RESET = 1'b1; START = 1'b1; SIMD = 1'b1; RES = 32'h1234_5678; CARRY = 4'hF; OVF = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_flags", {27'b0, FLAGS}, 32'd0);
      check("rst_we", {31'b0, FLAGS_WE}, 32'd0);
      check("rst_busy", {31'b0, BUSY}, 32'd0);
    end
    RESET = 1'b0; START = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("idle_we", {31'b0, FLAGS_WE}, 32'd0);
      check("idle_busy", {31'b0, BUSY}, 32'd0);
    end

    do_op("simd_zero", 1'b1, 32'h0000_0000, 4'b0000, 4'b0000, 5'b00001, 1'b0);
    do_op("simd_part", 1'b1, 32'h8000_7F00, 4'b0100, 4'b0001, 5'b11110, 1'b0);
    do_op("scalar", 1'b0, 32'h8000_0000, 4'b1000, 4'b0111, 5'b00110, 1'b0);
    do_op("scalar_zero", 1'b0, 32'h0000_0000, 4'b0111, 4'b1000, 5'b01001, 1'b0);
    do_op("busy_simd", 1'b1, 32'h0102_0304, 4'b0000, 4'b0000, 5'b00000, 1'b1);
    do_op("busy_scalar", 1'b0, 32'h0000_0100, 4'b0000, 4'b0000, 5'b00000, 1'b1);

    // Abort in the third SCAN cycle, with nonzero flags standing from before.
    do_op("pre_abort", 1'b1, 32'hFF00_0000, 4'b1111, 4'b0000, 5'b10110, 1'b0);
    START = 1'b1; SIMD = 1'b1; RES = 32'h0000_0000; CARRY = 4'h0; OVF = 4'h0;
    tick();
    START = 1'b0;
    tick();
    tick();
    check("abort_busy_pre", {31'b0, BUSY}, 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("abort_busy", {31'b0, BUSY}, 32'd0);
    check("abort_we", {31'b0, FLAGS_WE}, 32'd0);
    check("abort_flags", {27'b0, FLAGS}, 32'd0);
    held_flags = 5'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_we", {31'b0, FLAGS_WE}, 32'd0);
    end
    do_op("post_abort", 1'b1, 32'h0000_0080, 4'b0010, 4'b0100, 5'b11110, 1'b0);

    for (int k = 0; k < 40; k++) begin
      s = 1'($urandom_range(0, 1));
      r = $urandom;
      for (int i = 0; i < LANES; i++) begin
        if ($urandom_range(0, 1) == 0) r[i*LANE_W +: LANE_W] = 8'h00;
      end
      if ($urandom_range(0, 7) == 0) r = 32'h0;
      rc = 4'($urandom);
      ro = 4'($urandom);
      do_op("rand", s, r, rc, ro, model(s, r, rc, ro), 1'($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
